uart_send_frame: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8N1 sender. Adds configurable data width, parity, stop-bit count and a transmit FIFO, so that producers can push bytes back-to-back without polling busy. It sits between any byte producer (command encoder, debug streamer) and the board TX pin, on the single system clock.

---
 rtl/uart_send_frame_if.sv | 24 ++
 rtl/uart_send_frame.sv | 192 +++++++++++++++++++
 tb/tb_uart_send_frame.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_send_frame_if.sv
// uart_send_frame_if: producer-facing bundle of the UART transmitter.
// LevelW must equal the width of SendLevel in the attached transmitter.
interface uart_send_frame_if #(
    parameter int LevelW = 1
);
    logic              SendEn;
    logic [7:0]        SendData;
    logic              SendFull;
    logic [LevelW-1:0] SendLevel;
    logic              SendBusy;
    logic              SendDone;
    logic              SendOverflow;
    logic              UartTx;

    modport master (
        output SendEn, SendData,
        input  SendFull, SendLevel, SendBusy, SendDone, SendOverflow, UartTx
    );

    modport slave (
        input  SendEn, SendData,
        output SendFull, SendLevel, SendBusy, SendDone, SendOverflow, UartTx
    );
endinterface

// File: rtl/uart_send_frame.sv
// uart_send_frame: parametrised UART transmitter. Frame is a start bit,
// DataBits payload bits LSB first, optional parity and StopBits stop bits,
// each held BpsNum = SystemClk/Bps cycles. Writes are buffered.
// Build option UART_SEND_FIFO_EN: defined gives a FifoDepth-entry FIFO,
// undefined gives a single holding register (SendLevel is then 1 bit).
module uart_send_frame #(
    parameter int SystemClk  = 50000000,
    parameter int Bps        = 115200,
    parameter int DataBits   = 8,
    parameter int ParityMode = 0,
    parameter int StopBits   = 1,
    parameter int FifoDepth  = 16
) (
    input logic              clk,
    input logic              rst,
    uart_send_frame_if.slave bus
);
    localparam int BpsNum    = SystemClk / Bps;
    localparam int HasParity = (ParityMode != 0) ? 1 : 0;
    localparam int FrameBits = 1 + DataBits + HasParity + StopBits;
    localparam int CntW      = $clog2(BpsNum);
    localparam int IdxW      = $clog2(FrameBits);
`ifdef UART_SEND_FIFO_EN
    localparam int Depth     = FifoDepth;
`else
    localparam int Depth     = 1;
`endif
    localparam int LevelW    = $clog2(Depth + 1);

    localparam logic [CntW-1:0]   LastCnt = CntW'(BpsNum - 1);
    localparam logic [IdxW-1:0]   LastIdx = IdxW'(FrameBits - 1);
    localparam logic [LevelW-1:0] FullLvl = LevelW'(Depth);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     baud_q, baud_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [DataBits-1:0] data_q, data_d, head;
    logic [LevelW-1:0]   level_q, level_d;
    logic                full_q, full_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                push, pop, empty, last_bit, parity;
    logic [FrameBits-1:0] frame;

    assign empty    = (level_q == '0);
    assign push     = bus.SendEn && !full_q;
    assign last_bit = (state_q == SHIFT) && (baud_q == LastCnt) && (idx_q == LastIdx);

    // State register: controller state plus baud and bit counters
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: sequencing, buffer pop and counter advance
    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        baud_d  = '0;
        idx_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = LOAD;
                    pop     = 1'b1;
                end
            end
            LOAD: state_d = SHIFT;
            SHIFT: begin
                if (baud_q != LastCnt) begin
                    baud_d = baud_q + 1'b1;
                    idx_d  = idx_q;
                end else if (idx_q != LastIdx) begin
                    idx_d = idx_q + 1'b1;
                end else if (!empty) begin
                    state_d = LOAD;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame assembly from the latched payload: start, data, parity, stops
    always_comb begin
        parity             = (ParityMode == 1) ? ~(^data_q) : ^data_q;
        frame              = '1;
        frame[0]           = 1'b0;
        frame[DataBits:1]  = data_q;
        if (HasParity != 0) frame[DataBits+1] = parity;
    end

    // Output logic: next values of the registered line and status outputs
    always_comb begin
        tx_d    = (state_d == SHIFT) ? frame[idx_d] : 1'b1;
        busy_d  = (state_d == SHIFT) || ((state_d == LOAD) && (state_q == SHIFT));
        done_d  = last_bit;
        ovf_d   = bus.SendEn && full_q;
        level_d = level_q + LevelW'(push) - LevelW'(pop);
        full_d  = (level_d == FullLvl);
        data_d  = pop ? head : data_q;
    end

    // Output and payload registers; reset idles the line high at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            full_q  <= 1'b0;
            level_q <= '0;
            data_q  <= '0;
        end else begin
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            full_q  <= full_d;
            level_q <= level_d;
            data_q  <= data_d;
        end
    end

    // NOTE: buffer storage is not reset; level_q alone says which entries are valid.
`ifdef UART_SEND_FIFO_EN
    localparam int PtrW = $clog2(FifoDepth);

    logic [DataBits-1:0] mem_q [FifoDepth];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    assign head = mem_q[rd_ptr_q];

    // Pointer advance; power-of-two depth makes the wrap free
    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
    end

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.SendData[DataBits-1:0];
    end
`else
    logic [DataBits-1:0] hold_q, hold_d;

    assign head = hold_q;

    // Holding register captures an accepted write
    always_comb begin
        hold_d = push ? bus.SendData[DataBits-1:0] : hold_q;
    end

    // Holding register storage
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end
`endif

    assign bus.UartTx       = tx_q;
    assign bus.SendBusy     = busy_q;
    assign bus.SendDone     = done_q;
    assign bus.SendOverflow = ovf_q;
    assign bus.SendFull     = full_q;
    assign bus.SendLevel    = level_q;
endmodule

// File: tb/tb_uart_send_frame.sv
// tb_uart_send_frame: two transmitters (8 data/odd/1 stop at 4 cycles per
// bit, 7 data/even/2 stop at 3 cycles per bit) driven with random and
// directed writes and compared cycle by cycle against a frame-schedule model.
module tb_uart_send_frame;
`ifdef UART_SEND_FIFO_EN
    localparam int Depth = 4;
`else
    localparam int Depth = 1;
`endif
    localparam int LevelW = $clog2(Depth + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_send_frame_if #(.LevelW(LevelW)) bus_a ();
    uart_send_frame_if #(.LevelW(LevelW)) bus_b ();

    uart_send_frame #(
        .SystemClk(16), .Bps(4), .DataBits(8), .ParityMode(1), .StopBits(1), .FifoDepth(4)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    uart_send_frame #(
        .SystemClk(9), .Bps(3), .DataBits(7), .ParityMode(2), .StopBits(2), .FifoDepth(4)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: queued payloads and the line schedule of the
    // frame in flight (one line-high load cycle, then every bit BpsNum times).
    logic [7:0] mq [2][Depth];
    int         mq_n [2];
    logic       sch_tx [2][64];
    logic       sch_busy [2][64];
    int         sch_len [2];
    int         sch_pos [2];
    logic       prev_last [2];
    logic       exp_tx [2], exp_busy [2], exp_done [2], exp_ovf [2], exp_full [2];
    int         exp_level [2];

    function automatic int cfg_db(input int i);   return (i == 0) ? 8 : 7; endfunction
    function automatic int cfg_par(input int i);  return (i == 0) ? 1 : 2; endfunction
    function automatic int cfg_stop(input int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int cfg_bps(input int i);  return (i == 0) ? 4 : 3; endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq_n[i] = 0; sch_len[i] = 0; sch_pos[i] = 0; prev_last[i] = 1'b0;
            exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
            exp_ovf[i] = 1'b0; exp_full[i] = 1'b0; exp_level[i] = 0;
        end
    endtask

    // One clock edge of instance i with the write inputs present at that edge
    task automatic model_step(input int i, input logic en, input logic [7:0] data);
        logic       done_now, pop, acc;
        logic [7:0] b, mask;
        logic       fb [16];
        int         nb, ones, bps;
        bps      = cfg_bps(i);
        mask     = 8'hFF >> (8 - cfg_db(i));
        done_now = prev_last[i];
        pop      = (sch_pos[i] == sch_len[i]) && (mq_n[i] > 0);
        acc      = en && (mq_n[i] < Depth);
        exp_ovf[i] = en && !acc;
        if (pop) begin
            b = mq[i][0];
            for (int j = 0; j < Depth - 1; j++) mq[i][j] = mq[i][j+1];
            mq_n[i]--;
            ones  = $countones(b);
            fb[0] = 1'b0;
            nb    = 1;
            for (int j = 0; j < cfg_db(i); j++) begin fb[nb] = b[j]; nb++; end
            if (cfg_par(i) == 1) begin fb[nb] = (ones % 2 == 0); nb++; end
            if (cfg_par(i) == 2) begin fb[nb] = (ones % 2 == 1); nb++; end
            for (int j = 0; j < cfg_stop(i); j++) begin fb[nb] = 1'b1; nb++; end
            sch_tx[i][0]   = 1'b1;
            sch_busy[i][0] = done_now;
            for (int j = 0; j < nb; j++) begin
                for (int c = 0; c < bps; c++) begin
                    sch_tx[i][1 + j*bps + c]   = fb[j];
                    sch_busy[i][1 + j*bps + c] = 1'b1;
                end
            end
            sch_len[i] = 1 + nb * bps;
            sch_pos[i] = 0;
        end
        if (acc) begin
            mq[i][mq_n[i]] = data & mask;
            mq_n[i]++;
        end
        if (sch_pos[i] < sch_len[i]) begin
            exp_tx[i]   = sch_tx[i][sch_pos[i]];
            exp_busy[i] = sch_busy[i][sch_pos[i]];
            sch_pos[i]++;
            prev_last[i] = (sch_pos[i] == sch_len[i]);
        end else begin
            exp_tx[i]    = 1'b1;
            exp_busy[i]  = 1'b0;
            prev_last[i] = 1'b0;
        end
        exp_done[i]  = done_now;
        exp_level[i] = mq_n[i];
        exp_full[i]  = (mq_n[i] == Depth);
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check_val("a.tx",    int'(bus_a.UartTx),       int'(exp_tx[0]));
        check_val("a.busy",  int'(bus_a.SendBusy),     int'(exp_busy[0]));
        check_val("a.done",  int'(bus_a.SendDone),     int'(exp_done[0]));
        check_val("a.ovf",   int'(bus_a.SendOverflow), int'(exp_ovf[0]));
        check_val("a.full",  int'(bus_a.SendFull),     int'(exp_full[0]));
        check_val("a.level", int'(bus_a.SendLevel),    exp_level[0]);
        check_val("b.tx",    int'(bus_b.UartTx),       int'(exp_tx[1]));
        check_val("b.busy",  int'(bus_b.SendBusy),     int'(exp_busy[1]));
        check_val("b.done",  int'(bus_b.SendDone),     int'(exp_done[1]));
        check_val("b.ovf",   int'(bus_b.SendOverflow), int'(exp_ovf[1]));
        check_val("b.full",  int'(bus_b.SendFull),     int'(exp_full[1]));
        check_val("b.level", int'(bus_b.SendLevel),    exp_level[1]);
    endtask

    // Advance one clock: model follows the edge, outputs checked on the falling edge
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            model_step(0, bus_a.SendEn, bus_a.SendData);
            model_step(1, bus_b.SendEn, bus_b.SendData);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic en_a, input logic [7:0] d_a,
                         input logic en_b, input logic [7:0] d_b);
        bus_a.SendEn = en_a; bus_a.SendData = d_a;
        bus_b.SendEn = en_b; bus_b.SendData = d_b;
    endtask

    initial begin
        int pct;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        model_reset();

        // Reset values while reset is held
        repeat (3) step();
        rst = 1'b0;

        // Random traffic: idle, moderate, saturating, then draining
        for (int c = 0; c < 800; c++) begin
            pct = (c < 200) ? 2 : (c < 400) ? 30 : (c < 600) ? 85 : 0;
            drive($urandom_range(0, 99) < pct, 8'($urandom),
                  $urandom_range(0, 99) < pct, 8'($urandom));
            step();
        end

        // Burst of six consecutive writes, then drain
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 8'(8'h10 + k), 1'b1, 8'(8'h10 + k));
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (300) step();

        // Directed parity corner payloads, one at a time
        drive(1'b1, 8'h00, 1'b1, 8'h83);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (60) step();
        drive(1'b1, 8'hFF, 1'b1, 8'h7F);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (60) step();

        // Reset during a frame with writes queued behind it
        drive(1'b1, 8'hA5, 1'b1, 8'hA5);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        step();
        drive(1'b1, 8'h3C, 1'b1, 8'h3C);
        step();
        drive(1'b1, 8'hC3, 1'b1, 8'hC3);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (14) step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) step();
        rst = 1'b0;
        repeat (120) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
